fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the MIPS core. Owns the program counter by instantiating the existing `pc` register and driving its enable and next-value inputs. Issues one instruction request at a time over the SRAM-like instruction port. Resolves the next PC from sequential flow, taken branches (honouring the delay slot) and exception/ERET redirects, and buffers the returned instruction for decode under stall.

---
 rtl/cpu_defs.sv | 14 +
 rtl/pc.sv | 18 +
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, reset PC and exception vector.
package cpu_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

endpackage

// File: rtl/pc.sv
// Program counter register with load enable and asynchronous reset.
module pc #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding request, branch delay slot,
// exception/ERET redirect with discard of in-flight data, decode buffer.
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_d,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] instr_pc
);

  fetch_state_e     state_q, state_d;
  logic             inst_req_q, inst_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] instr_out_q, instr_out_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  logic             pend_br_q, pend_br_d;
  logic [WIDTH-1:0] br_tgt_q, br_tgt_d;

  logic             pc_en;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_cur;

  pc #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk(clk),
    .rst(rst),
    .en (pc_en),
    .d  (pc_d),
    .q  (pc_cur)
  );

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    req_pc_d      = req_pc_q;
    discard_d     = discard_q;
    pend_br_d     = pend_br_q;
    br_tgt_d      = br_tgt_q;
    pc_en         = 1'b0;
    pc_d          = pc_cur + WIDTH'(4);

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (inst_addr_ok) begin
          req_pc_d = pc_cur;
          pc_en    = 1'b1;
          if (pend_br_q) begin
            // the delay slot is the request being accepted now
            pc_d      = br_tgt_q;
            pend_br_d = 1'b0;
          end
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_out_d   = inst_rdata;
            instr_pc_d    = req_pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_d) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_taken) begin
      pend_br_d = 1'b1;
      br_tgt_d  = branch_target;
    end

    // redirect overrides everything above, including a same-cycle branch
    if (exc_valid) begin
      pend_br_d = 1'b0;
      pc_en     = 1'b1;
      pc_d      = exc_pc;
      case (state_q)
        S_REQ: if (inst_addr_ok) discard_d = 1'b1;
        S_WAIT: begin
          if (inst_data_ok) begin
            discard_d     = 1'b0;
            instr_valid_d = 1'b0;
            instr_out_d   = instr_out_q;
            instr_pc_d    = instr_pc_q;
            state_d       = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        S_HOLD: begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
        default: ;
      endcase
    end

    inst_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      inst_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      req_pc_q      <= '0;
      discard_q     <= 1'b0;
      pend_br_q     <= 1'b0;
      br_tgt_q      <= '0;
    end else begin
      state_q       <= state_d;
      inst_req_q    <= inst_req_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      req_pc_q      <= req_pc_d;
      discard_q     <= discard_d;
      pend_br_q     <= pend_br_d;
      br_tgt_q      <= br_tgt_d;
    end
  end

  assign inst_req    = inst_req_q;
  assign inst_addr   = pc_cur;
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (in-flight queue, decode buffer, pending branch).
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_d = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'hbfc0_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_d      (stall_d),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .instr_valid  (instr_valid),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        drop;
  } ent_t;

  ent_t        oq[$];
  logic [31:0] acc_log[$];
  bit          m_idle;
  bit          m_bv;
  bit          m_pend;
  logic [31:0] m_pc, m_tgt, m_buf, m_bpc;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c1d_0a7e;
  endfunction

  // a request is outstanding whenever nothing is in flight and decode is empty
  function automatic bit m_req();
    return !m_idle && oq.size() == 0 && !m_bv;
  endfunction

  task automatic model_reset();
    oq.delete();
    m_idle = 1'b1;
    m_bv   = 1'b0;
    m_pend = 1'b0;
    m_pc   = 32'hbfc0_0000;
    m_tgt  = '0;
    m_buf  = '0;
    m_bpc  = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("inst_req", {31'b0, inst_req}, {31'b0, m_req()});
    if (m_req()) chk("inst_addr", inst_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_bv});
    chk("instr_out", instr_out, m_buf);
    chk("instr_pc", instr_pc, m_bpc);
  endtask

  // drive one cycle of inputs, advance the model, then compare at the next negedge
  task automatic cycle(input bit r, input bit st, input bit br, input logic [31:0] bt,
                       input bit ex, input logic [31:0] ep, input bit aok, input bit dok);
    bit          req, acc, dat, had_buf;
    logic [31:0] cur;
    ent_t        e;
    rst           = r;
    stall_d       = st;
    branch_taken  = br;
    branch_target = bt;
    exc_valid     = ex;
    exc_pc        = ep;
    inst_addr_ok  = aok;
    inst_data_ok  = dok;
    inst_rdata    = (dok && oq.size() > 0) ? mem_word(oq[0].pc) : $urandom;
    if (r) begin
      model_reset();
    end else begin
      req     = m_req();
      acc     = req && aok;
      dat     = dok && oq.size() > 0;
      cur     = m_pc;
      had_buf = m_bv;
      m_idle  = 1'b0;
      if (dat) begin
        e = oq.pop_front();
        if (!e.drop && !ex) begin
          m_bv  = 1'b1;
          m_buf = inst_rdata;
          m_bpc = e.pc;
        end
      end
      if (acc) begin
        acc_log.push_back(cur);
        oq.push_back('{pc: cur, drop: ex});
      end
      if (ex) begin
        foreach (oq[i]) oq[i].drop = 1'b1;
        m_pc   = ep;
        m_pend = 1'b0;
        m_bv   = 1'b0;
      end else begin
        if (acc) begin
          m_pc   = m_pend ? m_tgt : cur + 32'd4;
          m_pend = 1'b0;
        end
        if (had_buf && !st) m_bv = 1'b0;
        if (br) begin
          m_pend = 1'b1;
          m_tgt  = bt;
        end
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_auto(input int n, input bit st);
    repeat (n) cycle(1'b0, st, 1'b0, '0, 1'b0, '0, 1'b1, oq.size() > 0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    chk("first_req", {31'b0, inst_req}, 32'd1);
    chk("first_addr", inst_addr, 32'hbfc0_0000);

    // zero-wait sequential fetch, ending with bfc00008 held in decode
    run_auto(8, 1'b0);
    chk("seq_acc0", acc_log[0], 32'hbfc0_0000);
    chk("seq_acc1", acc_log[1], 32'hbfc0_0004);
    chk("seq_acc2", acc_log[2], 32'hbfc0_0008);
    chk("seq_valid", {31'b0, instr_valid}, 32'd1);
    chk("seq_pc", instr_pc, 32'hbfc0_0008);
    chk("seq_data", instr_out, mem_word(32'hbfc0_0008));

    // stall for 5 cycles with a taken branch arriving during the stall
    cycle(1'b0, 1'b1, 1'b1, 32'hbfc0_0100, 1'b0, '0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_req", {31'b0, inst_req}, 32'd0);
    chk("stall_pc", instr_pc, 32'hbfc0_0008);
    run_auto(7, 1'b0);
    chk("delay_slot", acc_log[3], 32'hbfc0_000c);
    chk("br_target", acc_log[4], 32'hbfc0_0100);

    // exception in WAIT with a simultaneous branch that must be dropped
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'hbfc0_0380, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("exc_drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("exc_req", {31'b0, inst_req}, 32'd1);
    chk("exc_addr", inst_addr, 32'hbfc0_0380);
    run_auto(4, 1'b0);
    chk("exc_no_branch", acc_log[acc_log.size()-1], 32'hbfc0_0384);

    // reset in WAIT, then a stale data_ok right after release
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    chk("stale_valid", {31'b0, instr_valid}, 32'd0);
    chk("restart_addr", inst_addr, 32'hbfc0_0000);

    // PC wrap at the top of the address space
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hffff_fffc, 1'b0, 1'b0);
    chk("wrap_top", inst_addr, 32'hffff_fffc);
    run_auto(3, 1'b0);
    chk("wrap_req", {31'b0, inst_req}, 32'd1);
    chk("wrap_zero", inst_addr, 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 250) == 0,
            ($urandom % 3) == 0,
            ($urandom % 16) == 0, {$urandom, 2'b00} ,
            ($urandom % 32) == 0, {$urandom, 2'b00},
            ($urandom % 3) != 0,
            (oq.size() > 0) ? (($urandom % 2) == 0) : (($urandom % 8) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
